frame_fork: RTL and testbench

- Upstream stage of the motion-detection top.
- Pops 24-bit RGB frame pixels from the input frame FIFO and delivers each pixel, unchanged and in order, to two consumers:
  - the frame FIFO feeding fr_grayscale;
  - pre_highlight_frame_fifo, which feeds highlight.
- Guarantees both branches see identical pixel streams despite independent back-pressure.
- Tracks frame geometry and signals end-of-frame.

---
 rtl/motion_pkg.sv | 21 ++
 rtl/fork_branch.sv | 35 +++
 rtl/frame_fork.sv | 156 +++++++++++++++
 tb/tb_frame_fork.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motion_pkg
// Description : Shared types and default image geometry for the motion path.
// Revision    : 1.0 - initial release
// ============================================================================
package motion_pkg;

    localparam int c_data_width = 24;
    localparam int c_img_width  = 720;
    localparam int c_img_height = 540;

    typedef logic [c_data_width-1:0] rgb_t;

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_PUSH  = 1'b1
    } fork_state_t;

endpackage
`default_nettype wire

// File: rtl/fork_branch.sv
`default_nettype none
// ============================================================================
// Module      : fork_branch
// Description : Per-consumer pending flag and write strobe of the frame fork.
// Revision    : 1.0 - initial release
// ============================================================================
module fork_branch (
    input  logic clock,
    input  logic reset,
    input  logic i_load,
    input  logic i_full,
    output logic o_wr_en,
    output logic o_done
);

    logic r_pend;

    // Done means this branch has nothing left to deliver after this cycle.
    always_comb begin
        o_wr_en = reset & r_pend & ~i_full;
        o_done  = ~r_pend | o_wr_en;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend <= 1'b0;
        end else if (i_load) begin
            r_pend <= 1'b1;
        end else if (o_wr_en) begin
            r_pend <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_fork.sv
`default_nettype none
// ============================================================================
// Module      : frame_fork
// Description : Duplicates each input pixel into the grayscale and highlight
//               FIFOs and tracks frame geometry. FRAME_FORK_STALL_CNT_EN adds
//               a saturating back-pressure stall counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_fork
    import motion_pkg::*;
#(
    parameter int DATA_WIDTH      = c_data_width,
    parameter int IMG_WIDTH       = c_img_width,
    parameter int IMG_HEIGHT      = c_img_height,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_empty,
    input  logic [DATA_WIDTH-1:0]      in_dout,
    output logic                       in_rd_en,
    input  logic                       fr_full,
    output logic                       fr_wr_en,
    output logic [DATA_WIDTH-1:0]      fr_din,
    input  logic                       hl_full,
    output logic                       hl_wr_en,
    output logic [DATA_WIDTH-1:0]      hl_din,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       busy
`ifdef FRAME_FORK_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int c_col_w = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int c_row_w = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [c_col_w-1:0] c_last_col = c_col_w'(IMG_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(IMG_HEIGHT - 1);

    fork_state_t                r_state;
    fork_state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0]      r_hold;
    logic [c_col_w-1:0]         r_col;
    logic [c_row_w-1:0]         r_row;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_count;
    logic                       r_frame_done;
    logic                       w_fr_done;
    logic                       w_hl_done;
    logic                       w_done_now;
    logic                       w_pop;
    logic                       w_last_px;

    fork_branch u_fr (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_pop),
        .i_full  (fr_full),
        .o_wr_en (fr_wr_en),
        .o_done  (w_fr_done)
    );

    fork_branch u_hl (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_pop),
        .i_full  (hl_full),
        .o_wr_en (hl_wr_en),
        .o_done  (w_hl_done)
    );

    // A completing pixel may be replaced in the same cycle to keep 1 pixel/clock.
    always_comb begin
        w_state_nxt = r_state;
        w_done_now  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_pop = reset & ~in_empty;
                if (w_pop) begin
                    w_state_nxt = S_PUSH;
                end
            end
            S_PUSH: begin
                w_done_now = w_fr_done & w_hl_done;
                w_pop      = reset & w_done_now & ~in_empty;
                if (w_done_now && !w_pop) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_last_px   = (r_col == c_last_col) && (r_row == c_last_row);
    assign in_rd_en    = w_pop;
    assign fr_din      = r_hold;
    assign hl_din      = r_hold;
    assign busy        = reset & (r_state == S_PUSH);
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold        <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_frame_count <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_hold <= in_dout;
            end
            r_frame_done <= w_done_now & w_last_px;
            if (w_done_now) begin
                if (r_col == c_last_col) begin
                    r_col <= '0;
                    if (r_row == c_last_row) begin
                        r_row         <= '0;
                        r_frame_count <= r_frame_count + 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

`ifdef FRAME_FORK_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    // A held pixel that cannot complete means some pending branch is full.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if ((r_state == S_PUSH) && !w_done_now && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_fork.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_fork
// Description : Self-checking bench for frame_fork against an in-order stream
//               and pixel-count frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_fork;

    localparam int DW  = 24;
    localparam int W   = 3;
    localparam int H   = 2;
    localparam int FCW = 4;
    localparam int PPF = W * H;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           in_empty;
    logic [DW-1:0]  in_dout;
    logic           in_rd_en;
    logic           fr_full = 1'b0;
    logic           fr_wr_en;
    logic [DW-1:0]  fr_din;
    logic           hl_full = 1'b0;
    logic           hl_wr_en;
    logic [DW-1:0]  hl_din;
    logic           frame_done;
    logic [FCW-1:0] frame_count;
    logic           busy;
`ifdef FRAME_FORK_STALL_CNT_EN
    logic [31:0]    stall_cycles;
`endif

    // Upstream FIFO model and capture of both consumer streams.
    logic [DW-1:0] src_mem [0:1023];
    logic [DW-1:0] fr_mem  [0:1023];
    logic [DW-1:0] hl_mem  [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int fr_cnt = 0;
    int hl_cnt = 0;
    int src_base = 0;
    int fr_base  = 0;
    int hl_base  = 0;

    int checks = 0;
    int errors = 0;

    assign in_empty = (rd_ptr == wr_ptr);
    assign in_dout  = src_mem[rd_ptr[9:0]];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (in_rd_en) rd_ptr <= rd_ptr + 1;
        if (fr_wr_en) begin
            fr_mem[fr_cnt[9:0]] <= fr_din;
            fr_cnt <= fr_cnt + 1;
        end
        if (hl_wr_en) begin
            hl_mem[hl_cnt[9:0]] <= hl_din;
            hl_cnt <= hl_cnt + 1;
        end
    end

    frame_fork #(
        .DATA_WIDTH      (DW),
        .IMG_WIDTH       (W),
        .IMG_HEIGHT      (H),
        .FRAME_CNT_WIDTH (FCW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_empty    (in_empty),
        .in_dout     (in_dout),
        .in_rd_en    (in_rd_en),
        .fr_full     (fr_full),
        .fr_wr_en    (fr_wr_en),
        .fr_din      (fr_din),
        .hl_full     (hl_full),
        .hl_wr_en    (hl_wr_en),
        .hl_din      (hl_din),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .busy        (busy)
`ifdef FRAME_FORK_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push(input logic [DW-1:0] p);
        src_mem[wr_ptr[9:0]] = p;
        wr_ptr = wr_ptr + 1;
    endtask

    // Upstream FIFO is reset alongside the DUT, so unread words are flushed.
    task automatic do_reset();
        reset   = 1'b0;
        fr_full = 1'b0;
        hl_full = 1'b0;
        tick();
        tick();
        wr_ptr   = rd_ptr;
        src_base = wr_ptr;
        fr_base  = fr_cnt;
        hl_base  = hl_cnt;
        reset    = 1'b1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rd_ptr == wr_ptr && !busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Expected stream is every pixel pushed since the last reset, in order.
    function automatic int first_bad(input bit hl);
        int n;
        int got;
        logic [DW-1:0] g;
        n   = wr_ptr - src_base;
        got = hl ? (hl_cnt - hl_base) : (fr_cnt - fr_base);
        for (int k = 0; k < n && k < got; k++) begin
            g = hl ? hl_mem[hl_base + k] : fr_mem[fr_base + k];
            if (g !== src_mem[src_base + k]) return k;
        end
        if (got != n) return (got < n) ? got : n;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        push(24'h111111);
        tick();
        checks++; if (in_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", in_rd_en); end
        checks++; if (fr_wr_en !== 1'b0 || hl_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b%b expected 00", fr_wr_en, hl_wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (frame_count !== 4'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
        checks++; if (fr_din !== 24'h0 || hl_din !== 24'h0) begin errors++; $display("FAIL reset_hold: got %h/%h expected 0", fr_din, hl_din); end
        do_reset();
        tick();
        checks++; if (in_rd_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_empty: got rd=%b busy=%b expected 0/0", in_rd_en, busy); end
    endtask

    task automatic test_frame();
        bit ok;
        do_reset();
        for (int k = 1; k <= 6; k++) push(DW'(k));
        #1;
        checks++; if (in_rd_en !== 1'b1) begin errors++; $display("FAIL frame_first_pop: got %b expected 1", in_rd_en); end
        tick();
        for (int k = 1; k <= 6; k++) begin
            checks++; if (fr_wr_en !== 1'b1 || hl_wr_en !== 1'b1) begin errors++; $display("FAIL frame_wr_en[%0d]: got %b%b expected 11", k, fr_wr_en, hl_wr_en); end
            checks++; if (fr_din !== DW'(k) || hl_din !== DW'(k)) begin errors++; $display("FAIL frame_data[%0d]: got %h/%h expected %h", k, fr_din, hl_din, DW'(k)); end
            checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_early[%0d]: got %b expected 0", k, frame_done); end
            tick();
        end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_pulse: got %b expected 1", frame_done); end
        checks++; if (frame_count !== 4'd1) begin errors++; $display("FAIL frame_count_1: got %0d expected 1", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_end: got %b expected 0", busy); end
        tick();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_width: got %b expected 0", frame_done); end
        wait_idle(20, ok);
        checks++; if (first_bad(0) != -1 || first_bad(1) != -1) begin errors++; $display("FAIL frame_stream: got bad idx %0d/%0d expected -1/-1", first_bad(0), first_bad(1)); end
    endtask

    task automatic test_fr_stall();
        bit ok;
        do_reset();
        fr_full = 1'b1;
        push(24'hABCDEF);
        push(24'h123456);
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d]: got %b expected 1", i, busy); end
            checks++; if (fr_wr_en !== 1'b0) begin errors++; $display("FAIL stall_fr_wr[%0d]: got %b expected 0", i, fr_wr_en); end
            checks++; if (hl_wr_en !== (i == 0)) begin errors++; $display("FAIL stall_hl_wr[%0d]: got %b expected %b", i, hl_wr_en, (i == 0)); end
            checks++; if (in_rd_en !== 1'b0) begin errors++; $display("FAIL stall_no_pop[%0d]: got %b expected 0", i, in_rd_en); end
            tick();
        end
        fr_full = 1'b0;
        #1;
        checks++; if (fr_wr_en !== 1'b1 || fr_din !== 24'hABCDEF) begin errors++; $display("FAIL stall_release: got wr=%b din=%h expected 1/abcdef", fr_wr_en, fr_din); end
        checks++; if (in_rd_en !== 1'b1 || hl_wr_en !== 1'b0) begin errors++; $display("FAIL stall_release_pop: got rd=%b hl=%b expected 1/0", in_rd_en, hl_wr_en); end
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_idle: got timeout expected idle"); end
        checks++; if (fr_cnt - fr_base != 2 || hl_cnt - hl_base != 2) begin errors++; $display("FAIL stall_counts: got %0d/%0d expected 2/2", fr_cnt - fr_base, hl_cnt - hl_base); end
        checks++; if (first_bad(0) != -1 || first_bad(1) != -1) begin errors++; $display("FAIL stall_stream: got bad idx %0d/%0d expected -1/-1", first_bad(0), first_bad(1)); end
    endtask

    task automatic test_toggle();
        bit ok;
        do_reset();
        for (int k = 0; k < 100; k++) push(DW'($urandom));
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (rd_ptr == wr_ptr && !busy) begin
                ok = 1'b1;
                break;
            end
            fr_full = c[0];
            hl_full = ~c[0];
            tick();
        end
        fr_full = 1'b0;
        hl_full = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL toggle_idle: got timeout expected idle"); end
        checks++; if (fr_cnt - fr_base != 100 || hl_cnt - hl_base != 100) begin errors++; $display("FAIL toggle_counts: got %0d/%0d expected 100/100", fr_cnt - fr_base, hl_cnt - hl_base); end
        checks++; if (first_bad(0) != -1) begin errors++; $display("FAIL toggle_fr_stream: got bad idx %0d expected -1", first_bad(0)); end
        checks++; if (first_bad(1) != -1) begin errors++; $display("FAIL toggle_hl_stream: got bad idx %0d expected -1", first_bad(1)); end
        checks++; if (frame_count !== FCW'(100 / PPF)) begin errors++; $display("FAIL toggle_frames: got %0d expected %0d", frame_count, FCW'(100 / PPF)); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        for (int k = 0; k < 8; k++) push(DW'($urandom));
        for (int k = 0; k < 8; k++) tick();
        hl_full = 1'b1;
        tick();
        checks++; if (busy !== 1'b1 || fr_wr_en !== 1'b0 || hl_wr_en !== 1'b0) begin errors++; $display("FAIL mid_pending: got busy=%b fr=%b hl=%b expected 1/0/0", busy, fr_wr_en, hl_wr_en); end
        checks++; if (frame_count !== 4'd1) begin errors++; $display("FAIL mid_pre_count: got %0d expected 1", frame_count); end
        push(24'h0F0F0F);
        hl_full = 1'b0;
        reset   = 1'b0;
        #1;
        checks++; if (hl_wr_en !== 1'b0 || fr_wr_en !== 1'b0) begin errors++; $display("FAIL mid_async_wr: got %b%b expected 00", fr_wr_en, hl_wr_en); end
        checks++; if (in_rd_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async_rd: got rd=%b busy=%b expected 0/0", in_rd_en, busy); end
        checks++; if (frame_count !== 4'd0 || frame_done !== 1'b0) begin errors++; $display("FAIL mid_async_cnt: got %0d/%b expected 0/0", frame_count, frame_done); end
        do_reset();
        push(24'h777777);
        for (int k = 0; k < 4; k++) push(DW'($urandom));
        wait_idle(40, ok);
        checks++; if (first_bad(0) != -1 || first_bad(1) != -1) begin errors++; $display("FAIL mid_after_stream: got bad idx %0d/%0d expected -1/-1", first_bad(0), first_bad(1)); end
        checks++; if (frame_count !== 4'd0) begin errors++; $display("FAIL mid_geom_5: got %0d expected 0", frame_count); end
        push(DW'($urandom));
        wait_idle(40, ok);
        checks++; if (!ok || frame_count !== 4'd1) begin errors++; $display("FAIL mid_geom_6: got %0d expected 1", frame_count); end
    endtask

    task automatic test_wrap();
        bit ok;
        int prev;
        int done_px;
        int pulses;
        logic exp_fd;
        logic [FCW-1:0] exp_fc;
        do_reset();
        for (int k = 0; k < PPF * 16; k++) push(DW'($urandom));
        prev   = 0;
        pulses = 0;
        ok     = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (rd_ptr == wr_ptr && !busy) begin
                ok = 1'b1;
                break;
            end
            fr_full = ($urandom_range(0, 3) == 0);
            hl_full = ($urandom_range(0, 3) == 0);
            tick();
            done_px = (fr_cnt - fr_base < hl_cnt - hl_base) ? (fr_cnt - fr_base) : (hl_cnt - hl_base);
            exp_fd  = (done_px != prev) && (done_px % PPF == 0);
            exp_fc  = FCW'(done_px / PPF);
            checks++; if (frame_done !== exp_fd) begin errors++; $display("FAIL wrap_done@%0d: got %b expected %b", done_px, frame_done, exp_fd); end
            checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL wrap_count@%0d: got %0d expected %0d", done_px, frame_count, exp_fc); end
            if (frame_done === 1'b1) pulses++;
            prev = done_px;
        end
        fr_full = 1'b0;
        hl_full = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL wrap_idle: got timeout expected idle"); end
        checks++; if (pulses != 16) begin errors++; $display("FAIL wrap_pulses: got %0d expected 16", pulses); end
        checks++; if (frame_count !== 4'd0) begin errors++; $display("FAIL wrap_final: got %0d expected 0", frame_count); end
        checks++; if (first_bad(0) != -1 || first_bad(1) != -1) begin errors++; $display("FAIL wrap_stream: got bad idx %0d/%0d expected -1/-1", first_bad(0), first_bad(1)); end
    endtask

`ifdef FRAME_FORK_STALL_CNT_EN
    task automatic test_stall_cnt();
        bit ok;
        do_reset();
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL stallcnt_reset: got %0d expected 0", stall_cycles); end
        hl_full = 1'b1;
        push(DW'($urandom));
        tick();
        for (int i = 0; i < 7; i++) tick();
        hl_full = 1'b0;
        #1;
        checks++; if (stall_cycles !== 32'd7) begin errors++; $display("FAIL stallcnt_7: got %0d expected 7", stall_cycles); end
        wait_idle(20, ok);
        checks++; if (!ok || stall_cycles !== 32'd7) begin errors++; $display("FAIL stallcnt_hold: got %0d expected 7", stall_cycles); end
    endtask
`endif

    initial begin
        #1 reset = 1'b0;
        test_reset();
        test_frame();
        test_fr_stall();
        test_toggle();
        test_reset_mid();
        test_wrap();
`ifdef FRAME_FORK_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
